// File: rtl/dp_ram_pkg.sv
// Shared constants and types for the 64x8 true dual-port RAM.
// Default geometry lives here so the RAM and its users agree on widths.
package dp_ram_pkg;

   localparam int DATA_W_DEF = 8;
   localparam int ADDR_W_DEF = 6;
   localparam int DEPTH      = 2 ** ADDR_W_DEF;

   typedef logic [DATA_W_DEF-1:0] word_t;
   typedef logic [ADDR_W_DEF-1:0] addr_t;

endpackage : dp_ram_pkg

// File: rtl/dp_ram_port.sv
// Per-port read pipeline: decodes read enable, registers the read word and
// clears the output on synchronous reset.
module dp_ram_port #(
   parameter int DATA_W = dp_ram_pkg::DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rwe_i,
   input  logic [DATA_W-1:0] rd_word_i,
   output logic [DATA_W-1:0] data_out_o
);

   logic              rd_en;
   logic [DATA_W-1:0] data_d;
   logic [DATA_W-1:0] data_q;

   assign rd_en = ~rwe_i;

   // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      data_d = data_q;
      if (rd_en) begin
         data_d = rd_word_i;
      end
   end

   // NOTE: sequential state uses <= so all registers see pre-edge values regardless of block ordering.
   always_ff @(posedge clk) begin
      if (rst) begin
         data_q <= '0;
      end else begin
         data_q <= data_d;
      end
   end

   assign data_out_o = data_q;

endmodule : dp_ram_port

// File: rtl/dual_port_ram_64x8.sv
// True dual-port synchronous RAM, 64x8, two independent read/write ports on
// one clock. Read-before-write on collisions; port A wins write/write.
module dual_port_ram_64x8
   import dp_ram_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] data_a,
   input  logic [ADDR_W-1:0] addr_a,
   input  logic              RWE_a,
   output logic [DATA_W-1:0] data_outa,
   input  logic [DATA_W-1:0] data_b,
   input  logic [ADDR_W-1:0] addr_b,
   input  logic              RWE_b,
   output logic [DATA_W-1:0] data_outb
);

   localparam int MEM_DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] mem_q [MEM_DEPTH];
   logic              we_a;
   logic              we_b;
   logic [DATA_W-1:0] rd_word_a;
   logic [DATA_W-1:0] rd_word_b;

   assign we_a = RWE_a & ~rst;
   assign we_b = RWE_b & ~rst;

   // NOTE: the storage array has no reset; clearing it would block block-RAM inference and its contents must survive rst anyway.
   // Port A's write is ordered last so it overrides port B on an address collision.
   always_ff @(posedge clk) begin
      if (we_b) begin
         mem_q[addr_b] <= data_b;
      end
      if (we_a) begin
         mem_q[addr_a] <= data_a;
      end
   end

   // Pre-edge contents feed the read registers, giving read-before-write.
   assign rd_word_a = mem_q[addr_a];
   assign rd_word_b = mem_q[addr_b];

   dp_ram_port #(
      .DATA_W (DATA_W)
   ) u_port_a (
      .clk        (clk),
      .rst        (rst),
      .rwe_i      (RWE_a),
      .rd_word_i  (rd_word_a),
      .data_out_o (data_outa)
   );

   dp_ram_port #(
      .DATA_W (DATA_W)
   ) u_port_b (
      .clk        (clk),
      .rst        (rst),
      .rwe_i      (RWE_b),
      .rd_word_i  (rd_word_b),
      .data_out_o (data_outb)
   );

endmodule : dual_port_ram_64x8

// File: tb/tb_dual_port_ram_64x8.sv
// Directed self-checking bench for dual_port_ram_64x8.
// Each scenario task drives one or more cycles and compares outputs inline.
module tb_dual_port_ram_64x8;
   import dp_ram_pkg::*;

   logic  clk = 1'b0;
   logic  rst;
   word_t data_a, data_b, data_outa, data_outb;
   addr_t addr_a, addr_b;
   logic  RWE_a, RWE_b;

   int n_compared   = 0;
   int n_mismatched = 0;

   always #5 clk = ~clk;

   dual_port_ram_64x8 dut (
      .clk       (clk),
      .rst       (rst),
      .data_a    (data_a),
      .addr_a    (addr_a),
      .RWE_a     (RWE_a),
      .data_outa (data_outa),
      .data_b    (data_b),
      .addr_b    (addr_b),
      .RWE_b     (RWE_b),
      .data_outb (data_outb)
   );

   // Apply one cycle of stimulus, take the rising edge, settle 1 time unit.
   task automatic cycle(input logic r, input logic wa, input addr_t aa, input word_t da,
                        input logic wb, input addr_t ab, input word_t db);
      rst    = r;
      RWE_a  = wa; addr_a = aa; data_a = da;
      RWE_b  = wb; addr_b = ab; data_b = db;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      cycle(1'b1, 1'b0, 6'h00, 8'h00, 1'b0, 6'h00, 8'h00);
      cycle(1'b1, 1'b0, 6'h00, 8'h00, 1'b0, 6'h00, 8'h00);
      n_compared++;
      if (data_outa !== 8'h00) begin
         n_mismatched++; $display("FAIL reset_outa: got %h expected %h", data_outa, 8'h00);
      end
      n_compared++;
      if (data_outb !== 8'h00) begin
         n_mismatched++; $display("FAIL reset_outb: got %h expected %h", data_outb, 8'h00);
      end
   endtask

   task automatic test_write_read;
      // Cycles 0 and 1: A writes 0x33@0x01, B writes 0x44@0x02; outputs hold.
      cycle(1'b0, 1'b1, 6'h01, 8'h33, 1'b1, 6'h02, 8'h44);
      cycle(1'b0, 1'b1, 6'h01, 8'h33, 1'b1, 6'h02, 8'h44);
      n_compared++;
      if (data_outa !== 8'h00 || data_outb !== 8'h00) begin
         n_mismatched++; $display("FAIL write_hold: got %h/%h expected 00/00", data_outa, data_outb);
      end
      // Cycle 2: A writes 0x55@0x03, B reads 0x01.
      cycle(1'b0, 1'b1, 6'h03, 8'h55, 1'b0, 6'h01, 8'h00);
      n_compared++;
      if (data_outb !== 8'h33) begin
         n_mismatched++; $display("FAIL c2_outb: got %h expected %h", data_outb, 8'h33);
      end
      n_compared++;
      if (data_outa !== 8'h00) begin
         n_mismatched++; $display("FAIL c2_outa_hold: got %h expected %h", data_outa, 8'h00);
      end
   endtask

   task automatic test_back_to_back;
      // Cycle 3: A reads 0x02, B reads 0x03 (0x03 written the cycle before).
      cycle(1'b0, 1'b0, 6'h02, 8'h00, 1'b0, 6'h03, 8'h00);
      n_compared++;
      if (data_outa !== 8'h44) begin
         n_mismatched++; $display("FAIL c3_outa: got %h expected %h", data_outa, 8'h44);
      end
      n_compared++;
      if (data_outb !== 8'h55) begin
         n_mismatched++; $display("FAIL c3_outb: got %h expected %h", data_outb, 8'h55);
      end
      // Cycle 4: A reads 0x01, B writes 0x77@0x02.
      cycle(1'b0, 1'b0, 6'h01, 8'h00, 1'b1, 6'h02, 8'h77);
      n_compared++;
      if (data_outa !== 8'h33) begin
         n_mismatched++; $display("FAIL c4_outa: got %h expected %h", data_outa, 8'h33);
      end
      n_compared++;
      if (data_outb !== 8'h55) begin
         n_mismatched++; $display("FAIL c4_outb_hold: got %h expected %h", data_outb, 8'h55);
      end
      // Cycle 5: A reads 0x02, B reads 0x01.
      cycle(1'b0, 1'b0, 6'h02, 8'h00, 1'b0, 6'h01, 8'h00);
      n_compared++;
      if (data_outa !== 8'h77) begin
         n_mismatched++; $display("FAIL c5_outa: got %h expected %h", data_outa, 8'h77);
      end
      n_compared++;
      if (data_outb !== 8'h33) begin
         n_mismatched++; $display("FAIL c5_outb: got %h expected %h", data_outb, 8'h33);
      end
   endtask

   task automatic test_collision;
      // Write/write on 0x10: A wins.
      cycle(1'b0, 1'b1, 6'h10, 8'hAA, 1'b1, 6'h10, 8'hBB);
      cycle(1'b0, 1'b0, 6'h10, 8'h00, 1'b0, 6'h10, 8'h00);
      n_compared++;
      if (data_outa !== 8'hAA) begin
         n_mismatched++; $display("FAIL ww_outa: got %h expected %h", data_outa, 8'hAA);
      end
      n_compared++;
      if (data_outb !== 8'hAA) begin
         n_mismatched++; $display("FAIL ww_outb: got %h expected %h", data_outb, 8'hAA);
      end
      // A reads 0x10 while B writes 0xCC there: old data returned.
      cycle(1'b0, 1'b0, 6'h10, 8'h00, 1'b1, 6'h10, 8'hCC);
      n_compared++;
      if (data_outa !== 8'hAA) begin
         n_mismatched++; $display("FAIL rw_a_old: got %h expected %h", data_outa, 8'hAA);
      end
      cycle(1'b0, 1'b0, 6'h10, 8'h00, 1'b0, 6'h10, 8'h00);
      n_compared++;
      if (data_outa !== 8'hCC) begin
         n_mismatched++; $display("FAIL rw_a_new: got %h expected %h", data_outa, 8'hCC);
      end
      n_compared++;
      if (data_outb !== 8'hCC) begin
         n_mismatched++; $display("FAIL rw_b_new: got %h expected %h", data_outb, 8'hCC);
      end
   endtask

   task automatic test_reset_mid;
      // Reset with a pending A write of 0x99@0x01 and a B read.
      cycle(1'b1, 1'b1, 6'h01, 8'h99, 1'b0, 6'h02, 8'h00);
      n_compared++;
      if (data_outa !== 8'h00) begin
         n_mismatched++; $display("FAIL rst_mid_outa: got %h expected %h", data_outa, 8'h00);
      end
      n_compared++;
      if (data_outb !== 8'h00) begin
         n_mismatched++; $display("FAIL rst_mid_outb: got %h expected %h", data_outb, 8'h00);
      end
      cycle(1'b0, 1'b0, 6'h01, 8'h00, 1'b0, 6'h02, 8'h00);
      n_compared++;
      if (data_outa !== 8'h33) begin
         n_mismatched++; $display("FAIL rst_dropped_write: got %h expected %h", data_outa, 8'h33);
      end
      n_compared++;
      if (data_outb !== 8'h77) begin
         n_mismatched++; $display("FAIL rst_mem_kept: got %h expected %h", data_outb, 8'h77);
      end
   endtask

   task automatic test_boundary;
      cycle(1'b0, 1'b1, 6'h00, 8'h5A, 1'b1, 6'h3F, 8'hA5);
      cycle(1'b0, 1'b0, 6'h3F, 8'h00, 1'b0, 6'h00, 8'h00);
      n_compared++;
      if (data_outa !== 8'hA5) begin
         n_mismatched++; $display("FAIL bound_outa: got %h expected %h", data_outa, 8'hA5);
      end
      n_compared++;
      if (data_outb !== 8'h5A) begin
         n_mismatched++; $display("FAIL bound_outb: got %h expected %h", data_outb, 8'h5A);
      end
      // B reads 0x3F while A writes 0x11 there: B sees old word, then new.
      cycle(1'b0, 1'b1, 6'h3F, 8'h11, 1'b0, 6'h3F, 8'h00);
      n_compared++;
      if (data_outb !== 8'hA5) begin
         n_mismatched++; $display("FAIL rw_b_old: got %h expected %h", data_outb, 8'hA5);
      end
      n_compared++;
      if (data_outa !== 8'hA5) begin
         n_mismatched++; $display("FAIL rw_a_hold: got %h expected %h", data_outa, 8'hA5);
      end
      cycle(1'b0, 1'b0, 6'h00, 8'h00, 1'b0, 6'h3F, 8'h00);
      n_compared++;
      if (data_outb !== 8'h11) begin
         n_mismatched++; $display("FAIL rw_b_new: got %h expected %h", data_outb, 8'h11);
      end
      n_compared++;
      if (data_outa !== 8'h5A) begin
         n_mismatched++; $display("FAIL bound_a_zero: got %h expected %h", data_outa, 8'h5A);
      end
   endtask

   initial begin
      rst = 1'b1;
      RWE_a = 1'b0; addr_a = '0; data_a = '0;
      RWE_b = 1'b0; addr_b = '0; data_b = '0;
      test_reset();
      test_write_read();
      test_back_to_back();
      test_collision();
      test_reset_mid();
      test_boundary();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule : tb_dual_port_ram_64x8
